rr_arbiter4: RTL
================

# rr_arbiter4

Four-requester round-robin arbiter that shares one resource among requesters 1–4. Priority is selected by encoding logic with a rotating starting pointer. The block grants a single requester at a time, holds the grant until the owner releases it, and forces release after a programmable hold limit. Its encoded grant outputs (gnt_id plus valid) follow the same encoded-index-plus-valid convention as the 4:2 priority encoder, and they drive the shared resource's select mux.

## Interface
- MAX_HOLD, default 15: maximum consecutive cycles a grant may be held. 0 means no limit.
- clk  input  1  clock. All state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request lines. req[0] is requester 1 and req[3] is requester 4.
- done  input  1  release strobe from the current owner. Sampled only in GRANT.
- gnt  output  4  one-hot grant, registered.
- gnt_id  output  2  encoded index of the granted requester, registered.
- gnt_v  output  1  grant valid, registered. Qualifies gnt and gnt_id.
- timeout  output  1  one-cycle pulse flagging a forced release by the hold limit.

## Operation
- State: fsm ∈ {IDLE, GRANT}, ptr[1:0] (highest-priority index), hold_cnt (width $clog2(MAX_HOLD+1), minimum 1).
- Reset values: fsm=IDLE, ptr=0, hold_cnt=0, gnt=0000, gnt_id=00, gnt_v=0, timeout=0.
- IDLE, req=0000: remain in IDLE; gnt, gnt_id and gnt_v stay 0.
- IDLE, req≠0000: the winner is the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On the next edge: gnt=onehot(winner), gnt_id=winner, gnt_v=1, hold_cnt=1, fsm=GRANT.
- GRANT: the release condition, evaluated each edge, is any of:
  - (a) done=1;
  - (b) req[gnt_id]=0;
  - (c) MAX_HOLD≠0 and hold_cnt==MAX_HOLD.
- GRANT with no release: hold_cnt increments. It saturates at its maximum when MAX_HOLD=0. gnt, gnt_id and gnt_v are held.
- GRANT with release: on the next edge:
  - gnt=0000, gnt_id=00, gnt_v=0, hold_cnt=0, fsm=IDLE;
  - ptr=gnt_id+1 mod 4 (3 wraps to 0);
  - timeout=1 only if (c) holds and neither (a) nor (b) holds. Otherwise timeout=0.
- timeout is cleared on every edge where it is not set.
- During GRANT, changes on non-granted req bits are ignored. done in IDLE is ignored.
- Exactly one gnt bit is set whenever gnt_v=1. gnt==0000 whenever gnt_v=0.

## Timing
- Request-to-grant latency is 1 cycle from IDLE: req is sampled at edge n, and gnt_v=1 is seen after edge n.
- A mandatory idle bubble separates grants:
  - release is sampled at edge n;
  - gnt_v=0 for the cycle after edge n (timeout is visible in this cycle if set);
  - the earliest next grant is registered at edge n+1.
- Hold limit: with MAX_HOLD=M≠0 and no done or req drop, gnt_v is high for exactly M cycles.
- Simultaneous release conditions: (a) or (b) suppress timeout even when hold_cnt==MAX_HOLD.
- Reset mid-grant: at the reset edge all outputs go to their reset values and ptr=0. No timeout is issued. Reset has priority over every other condition.
- All outputs come directly from flops. There are no combinational input-to-output paths.

## Test plan
- Basic grant and release:
  - Stimulus: reset, then req=0001; pulse done in the 3rd GRANT cycle.
  - Required: gnt=0001, gnt_id=00, gnt_v=1 one cycle after req; gnt_v=0 the cycle after done; ptr=1.
- Fairness:
  - Stimulus: req=1111 held; pulse done one cycle after each gnt_v rises.
  - Required: gnt_id sequence 00, 01, 10, 11, 00, with a gnt_v=0 cycle between each grant.
- Pointer wrap:
  - Stimulus: reach ptr=3 by granting and releasing requester 3 (index 2), then apply req=0101.
  - Required: gnt_id=00, because the scan order is 3, 0.
- Hold limit (MAX_HOLD=4):
  - Stimulus: req=0010 held, done=0.
  - Required: gnt_v high exactly 4 cycles; timeout=1 in the following bubble cycle only; regrant gnt_id=01 one cycle later.
- Requester drop and precedence:
  - Stimulus: grant index 2, then set req[2]=0 on the cycle where hold_cnt==MAX_HOLD.
  - Required: release occurs and timeout stays 0.
- Reset mid-grant:
  - Stimulus: assert rst while gnt_v=1 with gnt_id=11.
  - Required: next edge gives gnt=0000, gnt_v=0, timeout=0; after rst drops with req=1111, the first grant is gnt_id=00.

Source files
------------

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter with a programmable hold limit.
// Grants one requester at a time; all outputs are registered.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_v,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] LIM  = CW'(MAX_HOLD);
    localparam logic [CW-1:0] CMAX = '1;

    state_t        state;
    state_t        state_n;
    logic [1:0]    ptr;
    logic [1:0]    ptr_n;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] cnt_n;
    logic [3:0]    gnt_n;
    logic [1:0]    id_n;
    logic          v_n;
    logic          to_n;

    logic [3:0]    rot;
    logic [3:0]    rot_oh;
    logic [1:0]    off;
    logic [1:0]    winner;
    logic [3:0]    win_oh;
    logic          rel_done;
    logic          rel_drop;
    logic          rel_lim;
    logic          release_c;

    // Rotate requests so bit 0 is the requester at the priority pointer.
    always_comb begin
        rot = req;
        unique case (ptr)
            2'd0: rot = req;
            2'd1: rot = {req[0], req[3:1]};
            2'd2: rot = {req[1:0], req[3:2]};
            2'd3: rot = {req[2:0], req[3]};
            default: rot = req;
        endcase
    end

    // Isolate the lowest set rotated bit, encode it and map back to an index.
    always_comb begin
        rot_oh = rot & (~rot + 4'd1);
        off    = 2'd0;
        unique case (1'b1)
            rot_oh[0]: off = 2'd0;
            rot_oh[1]: off = 2'd1;
            rot_oh[2]: off = 2'd2;
            rot_oh[3]: off = 2'd3;
            default:   off = 2'd0;
        endcase
        winner = ptr + off;
        win_oh = 4'b0001 << winner;
    end

    // Release causes for the current owner; a drop or done masks the timeout.
    always_comb begin
        rel_done  = done;
        rel_drop  = ~req[gnt_id];
        rel_lim   = (MAX_HOLD != 0) && (hold_cnt == LIM);
        release_c = rel_done | rel_drop | rel_lim;
    end

    // Next-state and next-output logic for the IDLE/GRANT controller.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = hold_cnt;
        gnt_n   = gnt;
        id_n    = gnt_id;
        v_n     = gnt_v;
        to_n    = 1'b0;
        unique case (state)
            IDLE: begin
                gnt_n = 4'b0000;
                id_n  = 2'd0;
                v_n   = 1'b0;
                cnt_n = '0;
                if (|req) begin
                    state_n = GRANT;
                    gnt_n   = win_oh;
                    id_n    = winner;
                    v_n     = 1'b1;
                    cnt_n   = CW'(1);
                end
            end
            GRANT: begin
                if (release_c) begin
                    state_n = IDLE;
                    gnt_n   = 4'b0000;
                    id_n    = 2'd0;
                    v_n     = 1'b0;
                    cnt_n   = '0;
                    ptr_n   = gnt_id + 2'd1;
                    to_n    = rel_lim & ~rel_done & ~rel_drop;
                end else if (hold_cnt != CMAX) begin
                    cnt_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over every other condition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            hold_cnt <= '0;
            gnt      <= 4'b0000;
            gnt_id   <= 2'd0;
            gnt_v    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= cnt_n;
            gnt      <= gnt_n;
            gnt_id   <= id_n;
            gnt_v    <= v_n;
            timeout  <= to_n;
        end
    end

    a_onehot : assert property (
        @(posedge clk) disable iff (rst) gnt_v |-> $onehot(gnt)
    );

    a_zero : assert property (
        @(posedge clk) disable iff (rst) !gnt_v |-> (gnt == 4'b0000)
    );

endmodule
